// File: rtl/cva6_lsu_mem_responder.sv
// Memory-side responder for the cva6 LSU load/store handshake.
// Serves one access at a time from a small word array and answers each request
// with a single-cycle response pulse after a fixed, per-channel latency.
module cva6_lsu_mem_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int LOAD_LAT  = 2,
    parameter int STORE_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_req_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              store_req_i,
    input  logic [ADDR_W-1:0] store_addr_i,
    input  logic [DATA_W-1:0] store_wdata_i,
    input  logic              stall_i,
    output logic              load_mem_resp_o,
    output logic [DATA_W-1:0] load_rdata_o,
    output logic              store_mem_resp_o,
    output logic              busy_o,
    output logic [7:0]        load_cnt_o,
    output logic [7:0]        store_cnt_o
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int MAXLAT = (LOAD_LAT > STORE_LAT) ? LOAD_LAT : STORE_LAT;
    localparam int CNT_W  = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_chan_store;
    logic                r_last_store;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [7:0]          r_load_cnt;
    logic [7:0]          r_store_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_grant;
    logic                w_grant_store;
    logic                w_resp;
    logic [IDX_W-1:0]    w_load_idx;
    logic [IDX_W-1:0]    w_store_idx;
    logic                w_unused_addr;

    // Byte-offset and upper address bits do not select a word; they alias.
    assign w_load_idx    = load_addr_i[2 +: IDX_W];
    assign w_store_idx   = store_addr_i[2 +: IDX_W];
    assign w_unused_addr = ^{load_addr_i[1:0], load_addr_i[ADDR_W-1:2+IDX_W],
                             store_addr_i[1:0], store_addr_i[ADDR_W-1:2+IDX_W]};

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Arbitration, latency countdown and next-state selection.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_grant       = 1'b0;
        w_grant_store = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_req_i || store_req_i) begin
                    w_grant       = 1'b1;
                    w_grant_store = store_req_i && (!load_req_i || !r_last_store);
                    if (w_grant_store) begin
                        w_cnt_next   = CNT_W'(STORE_LAT - 1);
                        w_state_next = (STORE_LAT > 1) ? BUSY : RESP;
                    end else begin
                        w_cnt_next   = CNT_W'(LOAD_LAT - 1);
                        w_state_next = (LOAD_LAT > 1) ? BUSY : RESP;
                    end
                end
            end
            BUSY: begin
                if (!stall_i) begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = RESP;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
            end
            RESP:    w_state_next = HOLD;
            HOLD:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Latch the granted access, retire it in RESP and track completions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_chan_store <= 1'b0;
            r_last_store <= 1'b1;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_load_cnt   <= '0;
            r_store_cnt  <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_grant) begin
                r_chan_store <= w_grant_store;
                r_idx        <= w_grant_store ? w_store_idx : w_load_idx;
                r_wdata      <= store_wdata_i;
            end
            if (w_resp) begin
                r_last_store <= r_chan_store;
                if (r_chan_store) begin
                    r_store_cnt <= r_store_cnt + 8'd1;
                end else begin
                    r_load_cnt <= r_load_cnt + 8'd1;
                end
            end
        end
    end

    // Backing array: cleared on reset, written only by a completing store.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_resp && r_chan_store) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign w_resp           = (r_state == RESP);
    assign load_mem_resp_o  = w_resp && !r_chan_store;
    assign store_mem_resp_o = w_resp && r_chan_store;
    assign load_rdata_o     = load_mem_resp_o ? r_mem[r_idx] : '0;
    assign busy_o           = (r_state != IDLE);
    assign load_cnt_o       = r_load_cnt;
    assign store_cnt_o      = r_store_cnt;

endmodule
